// File: rtl/ex_stage_if.sv
// ----------------------------------------------------------------------------
// ex_stage_if
// Bundles the ID/EX inputs and EX/MEM outputs of the execute stage.
//   master : the pipeline side (drives the *_in fields, observes stall_out and
//            the registered *_out fields).
//   slave  : the execute stage itself.
// Signals:
//   instr_in, imm_in, val_rs_in, val_rt_in, pc_in (32), rwd_in (5),
//   opcode_in (6)                      - instruction presented by ID/EX
//   stall_out (1)                      - upstream must hold and not advance
//   instr_out, imm_out, val_rs_out, val_rt_out, pc_out, alu_res_out (32),
//   rwd_out (5), opcode_out (6)        - EX/MEM register contents
// ----------------------------------------------------------------------------
interface ex_stage_if;
    logic [31:0] instr_in;
    logic [31:0] imm_in;
    logic [31:0] val_rs_in;
    logic [31:0] val_rt_in;
    logic [4:0]  rwd_in;
    logic [5:0]  opcode_in;
    logic [31:0] pc_in;

    logic        stall_out;
    logic [31:0] instr_out;
    logic [31:0] imm_out;
    logic [31:0] val_rs_out;
    logic [31:0] val_rt_out;
    logic [31:0] pc_out;
    logic [4:0]  rwd_out;
    logic [5:0]  opcode_out;
    logic [31:0] alu_res_out;

    modport master (
        output instr_in, imm_in, val_rs_in, val_rt_in, rwd_in, opcode_in, pc_in,
        input  stall_out, instr_out, imm_out, val_rs_out, val_rt_out, pc_out,
               rwd_out, opcode_out, alu_res_out
    );

    modport slave (
        input  instr_in, imm_in, val_rs_in, val_rt_in, rwd_in, opcode_in, pc_in,
        output stall_out, instr_out, imm_out, val_rs_out, val_rt_out, pc_out,
               rwd_out, opcode_out, alu_res_out
    );
endinterface

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage MIPS pipeline. Computes the ALU result or
// load/store address, owns HI/LO and an iterative (one bit per cycle)
// multiply/divide unit, and registers the EX/MEM fields for MEM.
// Ports:
//   clk    - pipeline clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - ex_stage_if.slave: ID/EX inputs, stall_out, EX/MEM outputs
// Parameters:
//   MD_CYCLES - BUSY iterations per mult/multu/div/divu (32 for 32-bit data)
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(MD_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        md_a;      // multiplicand / divisor magnitude
    logic [31:0]        md_hi;     // partial product high / remainder
    logic [31:0]        md_lo;     // multiplier / dividend -> quotient
    logic               md_div, neg_lo, neg_hi, div_zero;
    logic [31:0]        rs_save;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
        return neg ? (64'd0 - v) : v;
    endfunction

    // ---------------- decode ----------------
    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic               is_r, is_md, md_sgn, mthi_we, mtlo_we;
    logic signed [31:0] rs_s, rt_s, imm_s;

    assign funct   = bus.instr_in[5:0];
    assign shamt   = bus.instr_in[10:6];
    assign is_r    = (bus.opcode_in == 6'h00);
    assign is_md   = is_r && (funct[5:2] == 4'b0110);  // 18h..1Bh
    assign md_sgn  = ~funct[0];                        // mult/div are signed
    assign rs_s    = bus.val_rs_in;
    assign rt_s    = bus.val_rt_in;
    assign imm_s   = bus.imm_in;

    // Reset gates the stall so upstream is released the instant rst_n drops.
    assign bus.stall_out = rst_n && (((state == IDLE) && is_md) || (state == BUSY));

    assign mthi_we = !bus.stall_out && is_r && (funct == 6'h11);
    assign mtlo_we = !bus.stall_out && is_r && (funct == 6'h13);

    // ---------------- ALU ----------------
    logic [31:0] alu_res;

    always_comb begin
        alu_res = '0;
        if (is_r) begin
            case (funct)
                6'h21:   alu_res = bus.val_rs_in + bus.val_rt_in;
                6'h23:   alu_res = bus.val_rs_in - bus.val_rt_in;
                6'h24:   alu_res = bus.val_rs_in & bus.val_rt_in;
                6'h25:   alu_res = bus.val_rs_in | bus.val_rt_in;
                6'h26:   alu_res = bus.val_rs_in ^ bus.val_rt_in;
                6'h27:   alu_res = ~(bus.val_rs_in | bus.val_rt_in);
                6'h2A:   alu_res = {31'd0, rs_s < rt_s};
                6'h2B:   alu_res = {31'd0, bus.val_rs_in < bus.val_rt_in};
                6'h00:   alu_res = bus.val_rt_in << shamt;
                6'h02:   alu_res = bus.val_rt_in >> shamt;
                6'h03:   alu_res = rt_s >>> shamt;
                6'h10:   alu_res = hi_q;
                6'h12:   alu_res = lo_q;
                default: alu_res = '0;
            endcase
        end else begin
            case (bus.opcode_in)
                6'h09:   alu_res = bus.val_rs_in + bus.imm_in;
                6'h0A:   alu_res = {31'd0, rs_s < imm_s};
                6'h0B:   alu_res = {31'd0, bus.val_rs_in < bus.imm_in};
                6'h0C:   alu_res = bus.val_rs_in & {16'd0, bus.instr_in[15:0]};
                6'h0D:   alu_res = bus.val_rs_in | {16'd0, bus.instr_in[15:0]};
                6'h0E:   alu_res = bus.val_rs_in ^ {16'd0, bus.instr_in[15:0]};
                6'h0F:   alu_res = {bus.instr_in[15:0], 16'd0};
                6'h23,
                6'h2B:   alu_res = bus.val_rs_in + bus.imm_in;
                6'h03:   alu_res = bus.pc_in + 32'd8;
                default: alu_res = '0;
            endcase
        end
    end

    // ---------------- mult/div iteration step ----------------
    logic [32:0] mul_sum, div_sh;
    logic        div_ge;
    logic [31:0] step_hi, step_lo, fin_hi, fin_lo;
    logic [63:0] prod;

    always_comb begin
        mul_sum = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_a} : 33'd0);
        div_sh  = {md_hi, md_lo[31]};
        div_ge  = (div_sh >= {1'b0, md_a});
        if (md_div) begin
            step_hi = div_ge ? 32'(div_sh - {1'b0, md_a}) : div_sh[31:0];
            step_lo = {md_lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], md_lo[31:1]};
        end

        // Sign fix-up on the value produced by the final step.
        prod = cneg64({step_hi, step_lo}, neg_lo);
        if (!md_div) begin
            fin_hi = prod[63:32];
            fin_lo = prod[31:0];
        end else if (div_zero) begin
            fin_hi = rs_save;
            fin_lo = 32'hFFFF_FFFF;
        end else begin
            fin_hi = cneg32(step_hi, neg_hi);
            fin_lo = cneg32(step_lo, neg_lo);
        end
    end

    // ---------------- mult/div FSM and HI/LO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            md_a     <= '0;
            md_hi    <= '0;
            md_lo    <= '0;
            md_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            rs_save  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_md) begin
                        md_a     <= mag32(bus.val_rt_in, md_sgn);
                        md_lo    <= mag32(bus.val_rs_in, md_sgn);
                        md_hi    <= '0;
                        md_div   <= funct[1];
                        neg_lo   <= md_sgn && (bus.val_rs_in[31] ^ bus.val_rt_in[31]);
                        neg_hi   <= md_sgn && bus.val_rs_in[31];
                        div_zero <= funct[1] && (bus.val_rt_in == 32'd0);
                        rs_save  <= bus.val_rs_in;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    md_hi <= step_hi;
                    md_lo <= step_lo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(MD_CYCLES - 1)) begin
                        hi_q  <= fin_hi;
                        lo_q  <= fin_lo;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;  // DONE
            endcase
            if (mthi_we) hi_q <= bus.val_rs_in;
            if (mtlo_we) lo_q <= bus.val_rs_in;
        end
    end

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instr_out   <= '0;
            bus.imm_out     <= '0;
            bus.val_rs_out  <= '0;
            bus.val_rt_out  <= '0;
            bus.pc_out      <= '0;
            bus.rwd_out     <= '0;
            bus.opcode_out  <= '0;
            bus.alu_res_out <= '0;
        end else if (bus.stall_out) begin
            // Bubble: opcode 0 / rwd 0 means MEM neither stores nor writes back.
            bus.instr_out   <= '0;
            bus.imm_out     <= '0;
            bus.val_rs_out  <= '0;
            bus.val_rt_out  <= '0;
            bus.pc_out      <= '0;
            bus.rwd_out     <= '0;
            bus.opcode_out  <= '0;
            bus.alu_res_out <= '0;
        end else begin
            bus.instr_out   <= bus.instr_in;
            bus.imm_out     <= bus.imm_in;
            bus.val_rs_out  <= bus.val_rs_in;
            bus.val_rt_out  <= bus.val_rt_in;
            bus.pc_out      <= bus.pc_in;
            bus.rwd_out     <= bus.rwd_in;
            bus.opcode_out  <= bus.opcode_in;
            bus.alu_res_out <= alu_res;
        end
    end
endmodule
